// File: rtl/relu_wb_pkg.sv
// Shared definitions for the ReLU Wishbone slave: register offsets, opcodes,
// FSM state type and the rectifier function used by the datapath.
package relu_wb_pkg;

   localparam logic [3:0] OFF_CTRL   = 4'h0;
   localparam logic [3:0] OFF_DIN    = 4'h4;
   localparam logic [3:0] OFF_DOUT   = 4'h8;
   localparam logic [3:0] OFF_STATUS = 4'hC;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_RELU = 4'h5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic [31:0] relu32(input logic [31:0] v);
      relu32 = v[31] ? 32'h0000_0000 : v;
   endfunction

endpackage

// File: rtl/relu_core.sv
// ReLU datapath: snapshots the operand on start, counts RELU_LAT cycles,
// then presents a one-cycle valid together with the rectified result.
module relu_core
   import relu_wb_pkg::*;
#(
   parameter int unsigned RELU_LAT = 2
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_start,
   input  logic [31:0] i_din,
   output logic        o_valid,
   output logic [31:0] o_result
);

   logic        r_active;
   logic [3:0]  r_cnt;
   logic [31:0] r_snap;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_active <= 1'b0;
         r_cnt    <= 4'd0;
         r_snap   <= 32'h0000_0000;
      end else if (i_start) begin
         r_snap   <= i_din;
         r_cnt    <= 4'(RELU_LAT);
         r_active <= 1'b1;
      end else if (r_active) begin
         if (r_cnt == 4'd1) begin
            r_active <= 1'b0;
         end else begin
            r_cnt <= r_cnt - 4'd1;
         end
      end
   end

   // valid lands on the RELU_LAT-th edge after start, so the owner commits it there
   assign o_valid  = r_active && (r_cnt == 4'd1);
   assign o_result = relu32(r_snap);

endmodule

// File: rtl/relu_wb_slave.sv
// Wishbone slave exposing CTRL/DIN/DOUT/STATUS around a fixed-latency ReLU core;
// done doubles as a level interrupt.
module relu_wb_slave
   import relu_wb_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int unsigned RELU_LAT  = 2
) (
   input  logic        wb_clk_i,
   input  logic        rst_n,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        irq_o
);

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_ack;
   logic [31:0] r_dat;
   logic [31:0] r_din;
   logic [31:0] r_dout;
   logic [3:0]  r_opcode;
   logic        r_done;
   logic        r_err;

   logic        w_req;
   logic        w_in_win;
   logic        w_wr;
   logic [3:0]  w_off;
   logic        w_busy;
   logic        w_ctrl_wr;
   logic        w_din_wr;
   logic        w_stat_wr;
   logic        w_start;
   logic        w_bad_op;
   logic        w_busy_viol;
   logic        w_core_valid;
   logic [31:0] w_core_result;
   logic [31:0] w_rd_data;
   logic        w_unused_adr;

   // a held strobe is not re-served on the ack cycle, which rules out back-to-back acks
   assign w_req        = wbs_stb_i & wbs_cyc_i & ~r_ack;
   assign w_in_win     = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
   assign w_off        = {wbs_adr_i[3:2], 2'b00};
   assign w_unused_adr = ^wbs_adr_i[1:0];
   assign w_wr         = w_req & wbs_we_i & w_in_win;
   assign w_busy       = (r_state == ST_BUSY);
   assign w_ctrl_wr    = w_wr && (w_off == OFF_CTRL);
   assign w_din_wr     = w_wr && (w_off == OFF_DIN);
   assign w_stat_wr    = w_wr && (w_off == OFF_STATUS);
   assign w_start      = w_ctrl_wr && !w_busy && (wbs_dat_i[3:0] == OP_RELU);
   assign w_bad_op     = w_ctrl_wr && !w_busy &&
                         (wbs_dat_i[3:0] != OP_NOP) && (wbs_dat_i[3:0] != OP_RELU);
   assign w_busy_viol  = w_busy && (w_ctrl_wr || w_din_wr);

   relu_core #(.RELU_LAT(RELU_LAT)) u_core (
      .i_clk    (wb_clk_i),
      .i_rst_n  (rst_n),
      .i_start  (w_start),
      .i_din    (r_din),
      .o_valid  (w_core_valid),
      .o_result (w_core_result)
   );

   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_start) w_state_nxt = ST_BUSY;
            else         w_state_nxt = ST_IDLE;
         end
         ST_BUSY: begin
            if (w_core_valid) w_state_nxt = ST_DONE;
            else              w_state_nxt = ST_BUSY;
         end
         ST_DONE: begin
            if (w_start) w_state_nxt = ST_BUSY;
            else         w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_rd_data = 32'h0000_0000;
      if (w_in_win) begin
         case (w_off)
            OFF_CTRL:   w_rd_data = {28'h000_0000, r_opcode};
            OFF_DIN:    w_rd_data = r_din;
            OFF_DOUT:   w_rd_data = r_dout;
            OFF_STATUS: w_rd_data = {29'h0000_0000, r_err, r_done, w_busy};
            default:    w_rd_data = 32'h0000_0000;
         endcase
      end else begin
         w_rd_data = 32'h0000_0000;
      end
   end

   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         r_ack    <= 1'b0;
         r_dat    <= 32'h0000_0000;
         r_din    <= 32'h0000_0000;
         r_dout   <= 32'h0000_0000;
         r_opcode <= 4'h0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_ack <= w_req;
         r_dat <= (w_req && !wbs_we_i) ? w_rd_data : 32'h0000_0000;
         if (w_din_wr && !w_busy) begin
            for (int b = 0; b < 4; b++) begin
               if (wbs_sel_i[b]) r_din[8*b +: 8] <= wbs_dat_i[8*b +: 8];
            end
         end
         if (w_ctrl_wr && !w_busy) r_opcode <= wbs_dat_i[3:0];
         if (w_core_valid) r_dout <= w_core_result;
         // completion outranks a simultaneous W1C so a finished result is never lost
         if (w_core_valid) begin
            r_done <= 1'b1;
         end else if (w_start || (w_stat_wr && wbs_dat_i[1])) begin
            r_done <= 1'b0;
         end
         if (w_bad_op || w_busy_viol) begin
            r_err <= 1'b1;
         end else if (w_stat_wr && wbs_dat_i[2]) begin
            r_err <= 1'b0;
         end
      end
   end

   assign wbs_ack_o = r_ack;
   assign wbs_dat_o = r_dat;
   assign irq_o     = r_done;

endmodule

// File: tb/tb_relu_wb_slave.sv
// Self-checking bench for relu_wb_slave: per-feature tasks, read expectations
// queued at issue and retired when the acknowledged data returns.
module tb_relu_wb_slave;

   localparam logic [31:0] BASE = 32'h3000_0000;
   localparam logic [31:0] A_CTRL = BASE + 32'h0;
   localparam logic [31:0] A_DIN  = BASE + 32'h4;
   localparam logic [31:0] A_DOUT = BASE + 32'h8;
   localparam logic [31:0] A_STAT = BASE + 32'hC;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stb = 1'b0;
   logic        cyc = 1'b0;
   logic        we = 1'b0;
   logic [3:0]  sel = 4'h0;
   logic [31:0] adr = 32'h0;
   logic [31:0] dat_i = 32'h0;
   logic        ack;
   logic [31:0] dat_o;
   logic        irq;

   int n_checks = 0;
   int n_pass = 0;
   logic [31:0] exp_q[$];

   relu_wb_slave dut (
      .wb_clk_i (clk),
      .rst_n    (rst_n),
      .wbs_stb_i(stb),
      .wbs_cyc_i(cyc),
      .wbs_we_i (we),
      .wbs_sel_i(sel),
      .wbs_adr_i(adr),
      .wbs_dat_i(dat_i),
      .wbs_ack_o(ack),
      .wbs_dat_o(dat_o),
      .irq_o    (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd);
      int n;
      stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d; sel = s;
      @(posedge clk); #1;
      n = 1;
      while (ack !== 1'b1 && n < 8) begin
         @(posedge clk); #1;
         n++;
      end
      n_checks++;
      if (n != 1 || ack !== 1'b1) $display("FAIL ack_latency adr=%h: ack=%b after %0d cycles, required 1 after 1", a, ack, n);
      else n_pass++;
      rd = dat_o;
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (ack !== 1'b0 || dat_o !== 32'h0) $display("FAIL ack_width adr=%h: ack=%b dat=%h, required 0/0", a, ack, dat_o);
      else n_pass++;
   endtask

   task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] dummy;
      bus(1'b1, a, d, s, dummy);
   endtask

   task automatic wb_read(input logic [31:0] a, input logic [31:0] e,
                          output logic [31:0] rd, output logic [31:0] ex);
      exp_q.push_back(e);
      bus(1'b0, a, 32'h0, 4'hF, rd);
      ex = exp_q.pop_front();
   endtask

   task automatic test_reset();
      logic [31:0] rd, ex;
      logic [31:0] addrs [4];
      addrs = '{A_CTRL, A_DIN, A_DOUT, A_STAT};
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (ack !== 1'b0 || dat_o !== 32'h0 || irq !== 1'b0) $display("FAIL reset_outputs: ack=%b dat=%h irq=%b, required 0", ack, dat_o, irq);
      else n_pass++;
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
         wb_read(addrs[i], 32'h0, rd, ex);
         n_checks++;
         if (rd !== ex) $display("FAIL reset_reg%0d: got %h, required %h", i, rd, ex);
         else n_pass++;
      end
   endtask

   task automatic test_byte_enable();
      logic [31:0] rd, ex;
      wb_write(A_DIN, 32'hAABB_CCDD, 4'b0011);
      wb_read(A_DIN, 32'h0000_CCDD, rd, ex);
      n_checks++;
      if (rd !== ex) $display("FAIL din_sel_low: got %h, required %h", rd, ex);
      else n_pass++;
      wb_write(A_DIN, 32'hAABB_0000, 4'b1100);
      wb_read(A_DIN, 32'hAABB_CCDD, rd, ex);
      n_checks++;
      if (rd !== ex) $display("FAIL din_sel_high: got %h, required %h", rd, ex);
      else n_pass++;
   endtask

   task automatic test_relu();
      logic [31:0] rd, ex;
      logic [31:0] vals [7];
      logic [31:0] exps [7];
      vals = '{32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h5, 32'h8000_0000, 32'h7FFF_FFFF};
      exps = '{32'h0, 32'h0, 32'h0, 32'h1, 32'h5, 32'h0, 32'h7FFF_FFFF};
      for (int i = 0; i < 7; i++) begin
         wb_write(A_DIN, vals[i], 4'hF);
         wb_write(A_CTRL, 32'h5, 4'hF);
         wb_read(A_STAT, 32'h1, rd, ex);
         n_checks++;
         if (rd !== ex) $display("FAIL relu_busy[%0d]: status %h, required %h", i, rd, ex);
         else n_pass++;
         repeat (4) @(posedge clk);
         #1;
         wb_read(A_DOUT, exps[i], rd, ex);
         n_checks++;
         if (rd !== ex) $display("FAIL relu_dout[%0d] din=%h: got %h, required %h", i, vals[i], rd, ex);
         else n_pass++;
         wb_read(A_STAT, 32'h2, rd, ex);
         n_checks++;
         if (rd !== ex || irq !== 1'b1) $display("FAIL relu_done[%0d]: status %h irq %b, required %h irq 1", i, rd, irq, ex);
         else n_pass++;
      end
      wb_read(A_CTRL, 32'h5, rd, ex);
      n_checks++;
      if (rd !== ex) $display("FAIL ctrl_readback: got %h, required %h", rd, ex);
      else n_pass++;
   endtask

   task automatic test_w1c_race();
      logic [31:0] rd, ex;
      wb_write(A_STAT, 32'h2, 4'hF);
      wb_read(A_STAT, 32'h0, rd, ex);
      n_checks++;
      if (rd !== ex || irq !== 1'b0) $display("FAIL w1c_done: status %h irq %b, required %h irq 0", rd, irq, ex);
      else n_pass++;
      wb_write(A_DIN, 32'h11, 4'hF);
      wb_write(A_CTRL, 32'h5, 4'hF);
      wb_write(A_STAT, 32'h2, 4'hF);
      wb_read(A_STAT, 32'h2, rd, ex);
      n_checks++;
      if (rd !== ex || irq !== 1'b1) $display("FAIL w1c_vs_complete: status %h irq %b, required %h irq 1", rd, irq, ex);
      else n_pass++;
      wb_read(A_DOUT, 32'h11, rd, ex);
      n_checks++;
      if (rd !== ex) $display("FAIL w1c_race_dout: got %h, required %h", rd, ex);
      else n_pass++;
   endtask

   task automatic test_busy_write();
      logic [31:0] rd, ex;
      wb_write(A_DIN, 32'h3, 4'hF);
      wb_write(A_CTRL, 32'h5, 4'hF);
      wb_write(A_DIN, 32'h7, 4'hF);
      repeat (4) @(posedge clk);
      #1;
      wb_read(A_DOUT, 32'h3, rd, ex);
      n_checks++;
      if (rd !== ex) $display("FAIL busy_dout: got %h, required %h", rd, ex);
      else n_pass++;
      wb_read(A_STAT, 32'h6, rd, ex);
      n_checks++;
      if (rd !== ex) $display("FAIL busy_err: status %h, required %h", rd, ex);
      else n_pass++;
      wb_read(A_DIN, 32'h3, rd, ex);
      n_checks++;
      if (rd !== ex) $display("FAIL busy_din_kept: got %h, required %h", rd, ex);
      else n_pass++;
      wb_write(A_STAT, 32'h4, 4'hF);
      wb_read(A_STAT, 32'h2, rd, ex);
      n_checks++;
      if (rd !== ex) $display("FAIL w1c_err: status %h, required %h", rd, ex);
      else n_pass++;
   endtask

   task automatic test_illegal_op();
      logic [31:0] rd, ex;
      wb_write(A_STAT, 32'h6, 4'hF);
      wb_write(A_CTRL, 32'h3, 4'hF);
      wb_read(A_STAT, 32'h4, rd, ex);
      n_checks++;
      if (rd !== ex) $display("FAIL illegal_op_status: got %h, required %h", rd, ex);
      else n_pass++;
      wb_write(A_DOUT, 32'hDEAD_BEEF, 4'hF);
      wb_read(A_DOUT, 32'h3, rd, ex);
      n_checks++;
      if (rd !== ex) $display("FAIL dout_unchanged: got %h, required %h", rd, ex);
      else n_pass++;
      wb_read(BASE + 32'h40, 32'h0, rd, ex);
      n_checks++;
      if (rd !== ex) $display("FAIL out_of_range_read: got %h, required %h", rd, ex);
      else n_pass++;
      wb_write(BASE + 32'h40, 32'h5, 4'hF);
      wb_write(BASE + 32'h44, 32'h9, 4'hF);
      wb_read(A_STAT, 32'h4, rd, ex);
      n_checks++;
      if (rd !== ex) $display("FAIL out_of_range_write_status: got %h, required %h", rd, ex);
      else n_pass++;
      wb_read(A_DIN, 32'h3, rd, ex);
      n_checks++;
      if (rd !== ex) $display("FAIL out_of_range_write_din: got %h, required %h", rd, ex);
      else n_pass++;
      wb_write(A_STAT, 32'h4, 4'hF);
      wb_write(A_CTRL, 32'h0, 4'hF);
      wb_read(A_STAT, 32'h0, rd, ex);
      n_checks++;
      if (rd !== ex) $display("FAIL nop_status: got %h, required %h", rd, ex);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [1:0] pat [4];
      pat = '{2'b11, 2'b00, 2'b11, 2'b00};
      stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = A_DIN; sel = 4'hF;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) begin
            stb = 1'b0; cyc = 1'b0;
         end
         @(posedge clk); #1;
         n_checks++;
         if (ack !== pat[i][1] || (ack === 1'b1 && dat_o !== 32'h3) || (ack === 1'b0 && dat_o !== 32'h0))
            $display("FAIL back_to_back[%0d]: ack=%b dat=%h, required ack=%b", i, ack, dat_o, pat[i][1]);
         else n_pass++;
      end
   endtask

   task automatic test_reset_busy();
      logic [31:0] rd, ex;
      wb_write(A_DIN, 32'h9, 4'hF);
      wb_write(A_CTRL, 32'h5, 4'hF);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (irq !== 1'b0 || ack !== 1'b0 || dat_o !== 32'h0) $display("FAIL reset_busy_outputs: irq=%b ack=%b dat=%h, required 0", irq, ack, dat_o);
      else n_pass++;
      @(posedge clk); #3;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      wb_read(A_STAT, 32'h0, rd, ex);
      n_checks++;
      if (rd !== ex) $display("FAIL reset_busy_status: got %h, required %h", rd, ex);
      else n_pass++;
      wb_read(A_DOUT, 32'h0, rd, ex);
      n_checks++;
      if (rd !== ex || irq !== 1'b0) $display("FAIL reset_busy_dout: got %h irq %b, required %h irq 0", rd, irq, ex);
      else n_pass++;
      wb_write(A_DIN, 32'h1234_5678, 4'hF);
      wb_read(A_DIN, 32'h1234_5678, rd, ex);
      n_checks++;
      if (rd !== ex) $display("FAIL reset_busy_din: got %h, required %h", rd, ex);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_byte_enable();
      test_relu();
      test_w1c_race();
      test_busy_write();
      test_illegal_op();
      test_back_to_back();
      test_reset_busy();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/relu_wb_slave.md
RELU_WB_SLAVE -- requirements
Module: relu_wb_slave

Interface
REQ-001 Parameter BASE_ADDR, default 32'h3000_0000; base of the register window.
REQ-002 Parameter RELU_LAT, default 2; compute latency in cycles, legal range 1-15.
REQ-003 Port wb_clk_i, input, 1; the single clock, all logic on its rising edge.
REQ-004 Port rst_n, input, 1; asynchronous active-low reset.
REQ-005 Ports wbs_stb_i and wbs_cyc_i, input, 1 each; Wishbone strobe and cycle.
REQ-006 Port wbs_we_i, input, 1; high for write, low for read.
REQ-007 Port wbs_sel_i, input, 4; byte enables, used for writes.
REQ-008 Port wbs_adr_i, input, 32; byte address.
REQ-009 Port wbs_dat_i, input, 32; write data.
REQ-010 Port wbs_ack_o, output, 1; transfer acknowledge.
REQ-011 Port wbs_dat_o, output, 32; read data.
REQ-012 Port irq_o, output, 1; level-high interrupt, equal to the done flag.

Function
REQ-013 Register map is word-aligned at BASE_ADDR: 0x00 CTRL, 0x04 DIN, 0x08 DOUT, 0x0C STATUS.
- CTRL write: bits[3:0] are the opcode. CTRL read: {28'b0, opcode_last}.
- DIN: read/write signed 32-bit value.
- DOUT: read-only; writes are acked and ignored.
- STATUS: bit0 busy, bit1 done, bit2 err. Writing 1 to bit1 or bit2 clears that flag (W1C).
REQ-014 A request is stb&cyc high with ack low; the slave SHALL assert ack on the next edge for exactly one cycle, with no back-to-back ack.
REQ-015 Read data SHALL be registered on the edge that asserts ack and SHALL be valid while ack is high; it is 0 otherwise.
REQ-016 An address outside BASE_ADDR..BASE_ADDR+0x0F SHALL still be acked (no hang); reads return 0 and writes have no effect.
REQ-017 A DIN write SHALL honour wbs_sel_i per byte.
REQ-018 The FSM SHALL have three states: IDLE, BUSY, DONE.
- IDLE to BUSY on a CTRL write of 4'h5; busy=1 and done=0 on the ack edge; DIN is snapshot.
- BUSY to DONE after exactly RELU_LAT cycles: DOUT = snapshot[31] ? 0 : snapshot; done=1; busy=0.
- DONE to IDLE on the next cycle; the done flag stays set until W1C or a new start.
REQ-019 A CTRL write of 4'h0 is a NOP. Any other opcode SHALL set err and leave the FSM unchanged.
REQ-020 During BUSY, a CTRL or DIN write SHALL set err and be ignored; DOUT reads return the previous result.
REQ-021 A W1C to done and completion in the same cycle: completion wins, so done=1.
REQ-022 Result arithmetic is 32-bit two's complement. 0x8000_0000 maps to 0; 0x7FFF_FFFF passes through unchanged.

Reset
REQ-023 On rst_n low, asynchronously: FSM to IDLE; ack, dat_o, irq_o, DIN, DOUT, opcode and all flags to 0.
REQ-024 Reset during BUSY SHALL abort the operation with no result update. The first request after release SHALL be acked normally.

Structure
REQ-025 The shared package relu_wb_pkg holds the register offsets, the opcode constants (OP_NOP=4'h0, OP_RELU=4'h5) and the FSM state typedef.
REQ-026 The datapath is a sub-module relu_core: an input snapshot, a RELU_LAT-cycle latency counter, and a valid pulse plus 32-bit result output.

Verification
REQ-027 Write DIN=-5 (0xFFFF_FFFB), write CTRL=5, wait 4 cycles, read DOUT -> 0x0000_0000; STATUS reads 0x2.
REQ-028 Repeat the sequence with DIN values -1, 0, 1, 5 -> DOUT reads 0, 0, 1, 5. Each access sees ack for exactly one cycle, one cycle after the request.
REQ-029 CTRL=5 then an immediate DIN write of 7 while busy -> STATUS bit2=1 and DOUT equals the original input's result. W1C 0x4 -> err clears.
REQ-030 CTRL=4'h3 -> err=1, busy stays 0, DOUT unchanged. Read of BASE+0x40 -> acked, data 0.
REQ-031 Assert rst_n low one cycle after a start -> busy=0, DOUT=0, irq_o=0. The next DIN write is acked in one cycle.
REQ-032 DIN write of 0xAABB_CCDD with sel=4'b0011 over an initial DIN of 0 -> DIN reads 0x0000_CCDD.
